// File: rtl/host_mem_link.sv
// host_mem_link: moves words between a synchronous RAM and a byte-wide UART.
//   send: reads send_len words from address 0 upward and sends each one as
//         NB bytes, least-significant byte first.
//   recv: assembles NB received bytes per word (first byte lowest) and writes
//         recv_len words from address 0 upward.
// Optional feature macro: HOST_LINK_CHECKSUM_EN adds a trailing XOR checksum
// byte on send and expects one on receive (mismatch -> chk_err).
// Ports:
//   clk, rstN                      rising-edge clock, sync active-low reset
//   send_start, send_len           start pulse / word count for memory->UART
//   recv_start, recv_len           start pulse / word count for UART->memory
//   mem_addr, mem_rd_data          RAM address, read data (1-cycle latency)
//   mem_wr_en, mem_wr_data         RAM write strobe and data
//   txByteReady, txByteStart       UART transmitter handshake
//   byteForTx                      byte to transmit
//   rx_new_byte_indicate           one-cycle pulse per received byte
//   byteFromRx                     received byte
//   busy, send_done, recv_done     status
//   chk_err                        checksum mismatch on last receive
module host_mem_link #(
  parameter int  MEM_WORD_LENGTH = 48,
  parameter int  MEM_DEPTH       = 4096,
  parameter int  UART_WIDTH      = 8,
  localparam int ADDR_W          = $clog2(MEM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       send_start,
  input  logic                       recv_start,
  input  logic [ADDR_W:0]            send_len,
  input  logic [ADDR_W:0]            recv_len,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [MEM_WORD_LENGTH-1:0] mem_rd_data,
  output logic                       mem_wr_en,
  output logic [MEM_WORD_LENGTH-1:0] mem_wr_data,
  input  logic                       txByteReady,
  output logic                       txByteStart,
  output logic [UART_WIDTH-1:0]      byteForTx,
  input  logic                       rx_new_byte_indicate,
  input  logic [UART_WIDTH-1:0]      byteFromRx,
  output logic                       busy,
  output logic                       send_done,
  output logic                       recv_done,
  output logic                       chk_err
);

  localparam int NB    = (MEM_WORD_LENGTH + UART_WIDTH - 1) / UART_WIDTH;
  localparam int SR_W  = NB * UART_WIDTH;
  localparam int CNT_W = $clog2(NB + 1);

`ifdef HOST_LINK_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, TX_FETCH, TX_LOAD, TX_BYTE, TX_HOLD, RX_COLLECT, RX_WRITE, DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [ADDR_W:0]            words_q, words_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SR_W-1:0]            sr_q, sr_d;
  logic [UART_WIDTH-1:0]      chk_q, chk_d;
  logic                       chk_phase_q, chk_phase_d;
  logic                       tx_start_q, tx_start_d;
  logic [UART_WIDTH-1:0]      byte_tx_q, byte_tx_d;
  logic                       wr_en_q, wr_en_d;
  logic [MEM_WORD_LENGTH-1:0] wr_data_q, wr_data_d;
  logic                       busy_q, busy_d;
  logic                       send_done_q, send_done_d;
  logic                       recv_done_q, recv_done_d;
  logic                       chk_err_q, chk_err_d;

  logic [SR_W-1:0]            sr_in;
  logic [ADDR_W-1:0]          addr_inc;
  logic                       last_word;
  logic                       rx_take;

  // New byte enters at the top; after NB shifts the first byte sits lowest.
  assign sr_in     = SR_W'({byteFromRx, sr_q} >> UART_WIDTH);
  assign addr_inc  = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
  assign last_word = (words_q == (ADDR_W + 1)'(1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    words_d     = words_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    chk_d       = chk_q;
    chk_phase_d = chk_phase_q;
    tx_start_d  = 1'b0;
    byte_tx_d   = byte_tx_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    send_done_d = send_done_q;
    recv_done_d = recv_done_q;
    chk_err_d   = chk_err_q;
    rx_take     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (send_start || recv_start) begin
          send_done_d = 1'b0;
          recv_done_d = 1'b0;
          chk_err_d   = 1'b0;
          addr_d      = '0;
          cnt_d       = '0;
          chk_d       = '0;
          chk_phase_d = 1'b0;
          if (send_start) begin
            words_d = send_len;
            if (send_len == '0) begin
              state_d     = DONE;
              send_done_d = 1'b1;
            end else begin
              state_d = TX_FETCH;
            end
          end else begin
            words_d = recv_len;
            if (recv_len == '0) begin
              state_d     = DONE;
              recv_done_d = 1'b1;
            end else begin
              state_d = RX_COLLECT;
            end
          end
        end
      end
      TX_FETCH: state_d = TX_LOAD;
      TX_LOAD: begin
        sr_d    = SR_W'(mem_rd_data);
        cnt_d   = '0;
        state_d = TX_BYTE;
      end
      TX_BYTE: begin
        if (txByteReady) begin
          tx_start_d = 1'b1;
          byte_tx_d  = sr_q[UART_WIDTH-1:0];
          sr_d       = sr_q >> UART_WIDTH;
          chk_d      = chk_q ^ sr_q[UART_WIDTH-1:0];
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = TX_HOLD;
        end
      end
      TX_HOLD: begin
        if (chk_phase_q) begin
          state_d     = DONE;
          send_done_d = 1'b1;
        end else if (cnt_q == CNT_W'(NB)) begin
          if (last_word) begin
            if (CHK_EN) begin
              // Reuse TX_BYTE for the checksum trailer as a one-byte word.
              chk_phase_d = 1'b1;
              sr_d        = SR_W'(chk_q);
              state_d     = TX_BYTE;
            end else begin
              state_d     = DONE;
              send_done_d = 1'b1;
            end
          end else begin
            addr_d  = addr_inc;
            words_d = words_q - (ADDR_W + 1)'(1);
            state_d = TX_FETCH;
          end
        end else begin
          state_d = TX_BYTE;
        end
      end
      RX_COLLECT: rx_take = rx_new_byte_indicate;
      RX_WRITE: begin
        addr_d  = addr_inc;
        words_d = words_q - (ADDR_W + 1)'(1);
        state_d = RX_COLLECT;
        if (last_word) begin
          if (CHK_EN) begin
            chk_phase_d = 1'b1;
          end else begin
            state_d     = DONE;
            recv_done_d = 1'b1;
          end
        end
        // A byte landing during the write cycle starts the next word.
        rx_take = rx_new_byte_indicate && !(last_word && !CHK_EN);
      end
      default: state_d = IDLE;
    endcase

    if (rx_take) begin
      if (CHK_EN && chk_phase_d) begin
        chk_err_d   = (byteFromRx != chk_q);
        recv_done_d = 1'b1;
        state_d     = DONE;
      end else begin
        sr_d  = sr_in;
        chk_d = chk_q ^ byteFromRx;
        if (cnt_q == CNT_W'(NB - 1)) begin
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_data_d = sr_in[MEM_WORD_LENGTH-1:0];
          state_d   = RX_WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    busy_d = !(state_d inside {IDLE, DONE});
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      chk_q       <= '0;
      chk_phase_q <= 1'b0;
      tx_start_q  <= 1'b0;
      byte_tx_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      send_done_q <= 1'b0;
      recv_done_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      chk_q       <= chk_d;
      chk_phase_q <= chk_phase_d;
      tx_start_q  <= tx_start_d;
      byte_tx_q   <= byte_tx_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      send_done_q <= send_done_d;
      recv_done_q <= recv_done_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign txByteStart = tx_start_q;
  assign byteForTx   = byte_tx_q;
  assign busy        = busy_q;
  assign send_done   = send_done_q;
  assign recv_done   = recv_done_q;
  assign chk_err     = chk_err_q;

endmodule

// File: tb/tb_host_mem_link.sv
// Bench for host_mem_link with default parameters (48-bit words, 8-bit bytes).
// Table vectors pair a memory word with its byte stream written first-byte-
// leftmost; hand-written sequences cover the multi-cycle corner cases.
`timescale 1ns/1ps
module tb_host_mem_link;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        send_start = 1'b0, recv_start = 1'b0;
  logic [12:0] send_len = '0, recv_len = '0;
  logic [11:0] mem_addr;
  logic [47:0] mem_rd_data;
  logic        mem_wr_en;
  logic [47:0] mem_wr_data;
  logic        txByteReady = 1'b1;
  logic        txByteStart;
  logic [7:0]  byteForTx;
  logic        rx_new = 1'b0;
  logic [7:0]  byteFromRx = '0;
  logic        busy, send_done, recv_done, chk_err;

  always #5 clk = ~clk;

  host_mem_link #(.MEM_WORD_LENGTH(48), .MEM_DEPTH(4096), .UART_WIDTH(8)) dut (
    .clk(clk), .rstN(rstN),
    .send_start(send_start), .recv_start(recv_start),
    .send_len(send_len), .recv_len(recv_len),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .txByteReady(txByteReady), .txByteStart(txByteStart), .byteForTx(byteForTx),
    .rx_new_byte_indicate(rx_new), .byteFromRx(byteFromRx),
    .busy(busy), .send_done(send_done), .recv_done(recv_done), .chk_err(chk_err)
  );

  // Read-only RAM model with 1-cycle latency; DUT writes are logged, not stored.
  logic [47:0] mem [0:3];
  always @(posedge clk) mem_rd_data <= mem[mem_addr[1:0]];

  logic [7:0]  tx_q[$];
  logic [59:0] wr_q[$];
  always @(negedge clk) begin
    if (txByteStart) tx_q.push_back(byteForTx);
    if (mem_wr_en)   wr_q.push_back({mem_addr, mem_wr_data});
  end

  typedef struct {
    logic [47:0] word;
    logic [47:0] stream;  // byte sequence on the wire, first byte leftmost
  } vec_t;

  vec_t tx_tab[4];
  vec_t rx_tab[3];

  int          n_run = 0, n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_x;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sbyte(input logic [47:0] s, input int i);
    return s[47-8*i -: 8];
  endfunction

  task automatic expect_stream(input logic [47:0] s);
    for (int i = 0; i < 6; i++) exp_q.push_back(sbyte(s, i));
  endtask

  task automatic compare_tx(input string name, input int base);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < exp_q.size(); i++) x ^= exp_q[i];
`ifdef HOST_LINK_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    chk({name, " count"}, 64'(tx_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < tx_q.size())
        chk($sformatf("%s byte%0d", name, i), 64'(tx_q[base+i]), 64'(exp_q[i]));
  endtask

  task automatic do_send(input int len);
    send_len = 13'(len);
    send_start = 1'b1;
    tick;
    send_start = 1'b0;
  endtask

  task automatic do_recv(input int len);
    recv_len = 13'(len);
    recv_start = 1'b1;
    tick;
    recv_start = 1'b0;
  endtask

  task automatic wait_send(input string name);
    int k = 0;
    while (!send_done && k < 3000) begin tick; k++; end
    chk(name, 64'(send_done), 64'd1);
  endtask

  task automatic wait_recv(input string name);
    int k = 0;
    while (!recv_done && k < 3000) begin tick; k++; end
    chk(name, 64'(recv_done), 64'd1);
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap);
    byteFromRx = b;
    rx_new = 1'b1;
    tick;
    rx_new = 1'b0;
    repeat (gap) tick;
    rx_x ^= b;
  endtask

  task automatic rx_stream(input logic [47:0] s, input int gap);
    for (int i = 0; i < 6; i++) rx_byte(sbyte(s, i), gap);
  endtask

  task automatic rx_trailer;
`ifdef HOST_LINK_CHECKSUM_EN
    rx_byte(rx_x, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb, wb;
    tx_tab[0] = '{48'h0605_0403_0201, 48'h0102_0304_0506};
    tx_tab[1] = '{48'hA5A5_0000_FFFF, 48'hFFFF_0000_A5A5};
    tx_tab[2] = '{48'h8000_0000_0001, 48'h0100_0000_0080};
    tx_tab[3] = '{48'h1234_5678_9ABC, 48'hBC9A_7856_3412};
    rx_tab[0] = '{48'h1615_1413_1211, 48'h1112_1314_1516};
    rx_tab[1] = '{48'h2625_2423_2221, 48'h2122_2324_2526};
    rx_tab[2] = '{48'h5476_98BA_DCFE, 48'hFEDC_BA98_7654};
    for (int i = 0; i < 4; i++) mem[i] = '0;

    // Reset state
    repeat (2) tick;
    chk("rst busy", 64'(busy), 0);
    chk("rst send_done", 64'(send_done), 0);
    chk("rst recv_done", 64'(recv_done), 0);
    chk("rst chk_err", 64'(chk_err), 0);
    chk("rst txByteStart", 64'(txByteStart), 0);
    chk("rst mem_wr_en", 64'(mem_wr_en), 0);
    chk("rst byteForTx", 64'(byteForTx), 0);
    chk("rst mem_wr_data", 64'(mem_wr_data), 0);
    chk("rst mem_addr", 64'(mem_addr), 0);
    rstN = 1'b1;
    tick;

    // Single-word sends from the table
    for (int i = 0; i < 4; i++) begin
      mem[0] = tx_tab[i].word;
      exp_q.delete();
      expect_stream(tx_tab[i].stream);
      tb = tx_q.size();
      wb = wr_q.size();
      do_send(1);
      chk($sformatf("tx%0d busy", i), 64'(busy), 1);
      wait_send($sformatf("tx%0d done", i));
      tick;
      compare_tx($sformatf("tx%0d", i), tb);
      chk($sformatf("tx%0d no write", i), 64'(wr_q.size() - wb), 0);
      chk($sformatf("tx%0d idle", i), 64'(busy), 0);
      chk($sformatf("tx%0d recv_done", i), 64'(recv_done), 0);
    end

    // Two-word send: address advances between words
    mem[0] = tx_tab[1].word;
    mem[1] = tx_tab[3].word;
    exp_q.delete();
    expect_stream(tx_tab[1].stream);
    expect_stream(tx_tab[3].stream);
    tb = tx_q.size();
    do_send(2);
    wait_send("tx2w done");
    tick;
    compare_tx("tx2w", tb);

    // Three-word receive, bytes back to back so word boundaries hit RX_WRITE
    wb = wr_q.size();
    rx_x = '0;
    do_recv(3);
    for (int i = 0; i < 3; i++) rx_stream(rx_tab[i].stream, 0);
    rx_trailer();
    wait_recv("rx3 done");
    tick;
    chk("rx3 writes", 64'(wr_q.size() - wb), 3);
    for (int i = 0; i < 3; i++)
      if (wb + i < wr_q.size())
        chk($sformatf("rx3 word%0d", i), 64'(wr_q[wb+i]), {4'h0, 12'(i), rx_tab[i].word});
    chk("rx3 send_done", 64'(send_done), 0);
    chk("rx3 chk_err", 64'(chk_err), 0);

    // Simultaneous starts with send_len 0: send wins, done next cycle
    tb = tx_q.size();
    wb = wr_q.size();
    send_len = '0;
    recv_len = 13'd2;
    send_start = 1'b1;
    recv_start = 1'b1;
    tick;
    send_start = 1'b0;
    recv_start = 1'b0;
    chk("both send_done", 64'(send_done), 1);
    chk("both recv_done", 64'(recv_done), 0);
    chk("both busy", 64'(busy), 0);
    repeat (5) tick;
    chk("both no tx", 64'(tx_q.size() - tb), 0);
    chk("both no write", 64'(wr_q.size() - wb), 0);
    chk("both still done", 64'(send_done), 1);

    // recv_len 0 from DONE clears send_done and raises recv_done
    do_recv(0);
    chk("rx0 recv_done", 64'(recv_done), 1);
    chk("rx0 send_done", 64'(send_done), 0);

    // Transmitter stalled 100 cycles; a recv_start meanwhile is ignored
    txByteReady = 1'b0;
    mem[0] = tx_tab[0].word;
    exp_q.delete();
    expect_stream(tx_tab[0].stream);
    tb = tx_q.size();
    wb = wr_q.size();
    do_send(1);
    repeat (50) tick;
    do_recv(1);
    repeat (50) tick;
    chk("stall no tx", 64'(tx_q.size() - tb), 0);
    chk("stall busy", 64'(busy), 1);
    txByteReady = 1'b1;
    wait_send("stall done");
    tick;
    compare_tx("stall", tb);
    chk("stall recv_done", 64'(recv_done), 0);
    chk("stall no write", 64'(wr_q.size() - wb), 0);

    // Reset part-way through a word, then a fresh single-word receive
    do_recv(2);
    rx_byte(8'hAA, 1);
    rx_byte(8'hBB, 1);
    rx_byte(8'hCC, 1);
    rstN = 1'b0;
    tick;
    chk("abort busy", 64'(busy), 0);
    chk("abort recv_done", 64'(recv_done), 0);
    chk("abort mem_wr_en", 64'(mem_wr_en), 0);
    chk("abort mem_addr", 64'(mem_addr), 0);
    chk("abort mem_wr_data", 64'(mem_wr_data), 0);
    chk("abort byteForTx", 64'(byteForTx), 0);
    rstN = 1'b1;
    tick;
    wb = wr_q.size();
    rx_x = '0;
    do_recv(1);
    rx_stream(48'h3132_3334_3536, 1);
    rx_trailer();
    wait_recv("renew done");
    tick;
    chk("renew writes", 64'(wr_q.size() - wb), 1);
    if (wb < wr_q.size()) chk("renew word", 64'(wr_q[wb]), {16'h0000, 48'h3635_3433_3231});

`ifdef HOST_LINK_CHECKSUM_EN
    // Bad then good checksum trailer
    wb = wr_q.size();
    rx_x = '0;
    do_recv(1);
    rx_stream(48'h0102_0304_0506, 1);
    rx_byte(8'h00, 1);
    wait_recv("csum bad done");
    chk("csum bad chk_err", 64'(chk_err), 1);
    chk("csum bad writes", 64'(wr_q.size() - wb), 1);
    do_recv(1);
    chk("csum cleared", 64'(chk_err), 0);
    rx_stream(48'h0102_0304_0506, 1);
    rx_byte(8'h07, 1);
    wait_recv("csum good done");
    chk("csum good chk_err", 64'(chk_err), 0);
`else
    chk("chk_err tied", 64'(chk_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/host_mem_link.md
HOST_MEM_LINK -- requirements
Module: host_mem_link

Interface
REQ-001 SHALL have parameter MEM_WORD_LENGTH, default 48, bits per memory word.
REQ-002 SHALL have parameter MEM_DEPTH, default 4096, words addressable; ADDR_W = $clog2(MEM_DEPTH).
REQ-003 SHALL have parameter UART_WIDTH, default 8, bits per UART byte; NB = ceil(MEM_WORD_LENGTH/UART_WIDTH) bytes per word.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rstN, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports send_start and recv_start, input, 1 each, single-cycle start pulses.
REQ-007 SHALL have ports send_len and recv_len, input, ADDR_W+1 each, word counts sampled on their start pulse.
REQ-008 SHALL have ports mem_addr (output, ADDR_W), mem_rd_data (input, MEM_WORD_LENGTH), mem_wr_en (output, 1), mem_wr_data (output, MEM_WORD_LENGTH): synchronous RAM port with 1-cycle read latency.
REQ-009 SHALL have ports txByteReady (input, 1), txByteStart (output, 1), byteForTx (output, UART_WIDTH) to the UART transmitter.
REQ-010 SHALL have ports rx_new_byte_indicate (input, 1, one-cycle pulse per byte) and byteFromRx (input, UART_WIDTH) from the UART receiver.
REQ-011 SHALL have outputs busy, send_done, recv_done, chk_err, 1 bit each.

Function
REQ-012 SHALL implement states IDLE, TX_FETCH, TX_LOAD, TX_BYTE, TX_HOLD, RX_COLLECT, RX_WRITE, DONE.
REQ-013 IDLE: send_start -> TX_FETCH, address 0, word count send_len; else recv_start -> RX_COLLECT, address 0, count recv_len; both high -> send wins, recv_start dropped.
REQ-014 Start pulses outside IDLE/DONE SHALL be ignored.
REQ-015 Length 0 SHALL go straight to DONE with the matching done flag one cycle after the start pulse, with no memory or UART activity.
REQ-016 TX_FETCH drives mem_addr for one cycle; TX_LOAD captures mem_rd_data into the word shift register.
REQ-017 TX_BYTE: when txByteReady=1, SHALL pulse txByteStart for exactly one cycle with byteForTx = current least-significant byte (little-endian byte order), then TX_HOLD.
REQ-018 TX_HOLD SHALL ignore txByteReady for one cycle, then return to TX_BYTE for the next byte; after byte NB-1, advance address and go to TX_FETCH, or DONE after the last word.
REQ-019 Bits of the final byte above MEM_WORD_LENGTH SHALL be transmitted as 0.
REQ-020 RX_COLLECT: each rx_new_byte_indicate shifts byteFromRx into the word register little-endian; after NB bytes -> RX_WRITE.
REQ-021 RX_WRITE SHALL assert mem_wr_en for exactly one cycle with mem_wr_data = assembled word (excess high bits discarded); address advances; -> RX_COLLECT or DONE after the last word.
REQ-022 A byte pulse arriving during RX_WRITE SHALL be accepted as byte 0 of the next word (no loss).
REQ-023 DONE SHALL hold send_done or recv_done high until the next accepted start, which clears it the same cycle the new state is entered.
REQ-024 busy SHALL be 1 in every state except IDLE and DONE.
REQ-025 mem_addr SHALL wrap modulo MEM_DEPTH; mem_wr_en SHALL be 0 in all tx states.

Reset
REQ-026 rstN=0 at a clock edge SHALL force IDLE, address 0, counters 0, and txByteStart, mem_wr_en, busy, send_done, recv_done, chk_err to 0, byteForTx 0, mem_wr_data 0, aborting any transfer mid-word.

Configuration
REQ-027 Macro HOST_LINK_CHECKSUM_EN defined: tx appends one byte = XOR of all sent bytes after the last word; rx expects one trailing byte, sets chk_err=1 in DONE if it differs from XOR of received bytes, and writes no memory for it.
REQ-028 Macro undefined: no checksum byte sent or expected; chk_err tied 0.

Verification
REQ-029 send_len=1, mem[0]=48'h0605_0403_0201, txByteReady=1 -> bytes 01,02,03,04,05,06 in order, each as a one-cycle txByteStart, then send_done=1.
REQ-030 recv_len=2, rx bytes 11..16 then 21..26 -> mem_wr_en at addr 0 with 48'h1615_1413_1211, at addr 1 with 48'h2625_2423_2221, recv_done=1.
REQ-031 send_start and recv_start same cycle, send_len=0 -> DONE next cycle, send_done=1, recv_done=0, no txByteStart.
REQ-032 txByteReady held 0 for 100 cycles during TX_BYTE -> no txByteStart, busy=1; release -> next byte sent.
REQ-033 rstN=0 after 3 of 6 rx bytes -> IDLE, outputs 0; new recv_len=1 transfer completes with only new bytes.
REQ-034 With HOST_LINK_CHECKSUM_EN, recv_len=1, bytes 01..06 then 00 -> chk_err=1 (expected 07); trailer 07 -> chk_err=0.
